// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial arithmetic controller.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial WIDTH-bit arithmetic controller around an external 4-bit unit.
//
// state | meaning
// IDLE  | waiting for start; result/c_out/zero hold the last operation
// RUN   | one nibble per clock, LSB first, carry chained through a register
// DONE  | one-cycle completion pulse, then back to IDLE
module nibble_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic                c_in,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                c_out,
    output logic                zero,
    output logic [3:0]          au_a,
    output logic [3:0]          au_b,
    output logic [1:0]          au_s,
    output logic                au_c_in,
    input  logic [3:0]          au_d,
    input  logic                au_c_out
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   next_result;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Present the current nibble pair to the arithmetic unit; idle values outside RUN.
    always_comb begin
        au_a    = '0;
        au_b    = '0;
        au_s    = op_q;
        au_c_in = 1'b0;
        if (state == RUN) begin
            au_c_in = carry;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IDX_W'(i)) begin
                    au_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                    au_b = b_q[i*NIBBLE_W +: NIBBLE_W];
                end
            end
        end
    end

    // Result with the unit's sum nibble inserted at the current position.
    always_comb begin
        next_result = result;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                next_result[i*NIBBLE_W +: NIBBLE_W] = au_d;
            end
        end
    end

    // Sequencer: latch operands on start, walk the nibbles, flag completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            result <= '0;
            c_out  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        carry  <= c_in;
                        idx    <= '0;
                        result <= '0;
                        c_out  <= 1'b0;
                        zero   <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result <= next_result;
                    carry  <= au_c_out;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        c_out <= au_c_out;
                        zero  <= (next_result == '0);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: behavioural 4-bit unit on au_*, full-width reference model,
// per-cycle compare plus literal scenario checks.
module tb_nibble_serial_alu_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          c_in = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, c_out, zero;
    logic [W-1:0]  result;
    logic [3:0]    au_a, au_b, au_d;
    logic [1:0]    au_s;
    logic          au_c_in, au_c_out;

    int errors = 0;
    int checks = 0;

    nibble_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .c_in(c_in),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .c_out(c_out), .zero(zero), .au_a(au_a), .au_b(au_b), .au_s(au_s),
        .au_c_in(au_c_in), .au_d(au_d), .au_c_out(au_c_out)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit arithmetic unit.
    always_comb begin
        logic [3:0] bsel;
        case (au_s)
            2'b00:   bsel = au_b;
            2'b01:   bsel = ~au_b;
            2'b10:   bsel = 4'h0;
            default: bsel = 4'hF;
        endcase
        {au_c_out, au_d} = {1'b0, au_a} + {1'b0, bsel} + {4'b0, au_c_in};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] eff_b(input logic [1:0] o, input logic [W-1:0] bb);
        case (o)
            2'b00:   return bb;
            2'b01:   return ~bb;
            2'b10:   return '0;
            default: return '1;
        endcase
    endfunction

    function automatic logic [W-1:0] low_mask(input int k);
        logic [W:0] one = 1;
        if (k >= N) return '1;
        return W'((one << (4 * k)) - 1);
    endfunction

    // Reference model: whole-width sum, revealed one nibble per cycle.
    int          m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]  m_op = 2'b00;
    logic        m_cin = 1'b0, m_cout = 1'b0, m_zero = 1'b0;
    logic [W:0]  m_full = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_a = '0; m_b = '0; m_op = 2'b00; m_cin = 1'b0;
            m_res = '0; m_cout = 1'b0; m_zero = 1'b0; m_full = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_a = a; m_b = b; m_op = op; m_cin = c_in;
                m_full = {1'b0, a} + {1'b0, eff_b(op, b)} + {{W{1'b0}}, c_in};
                m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
                m_cnt = 1;
            end
        end else if (m_cnt <= N) begin
            m_res = m_full[W-1:0] & low_mask(m_cnt);
            if (m_cnt == N) begin
                m_cout = m_full[W];
                m_zero = (m_full[W-1:0] == '0);
            end
            m_cnt++;
        end else begin
            m_cnt = 0;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic       e_busy;
        logic [3:0] e_a, e_b;
        logic       e_ci;
        logic [W:0] part;
        int         k;
        e_busy = (m_cnt >= 1 && m_cnt <= N);
        e_a = 4'h0; e_b = 4'h0; e_ci = 1'b0;
        if (e_busy) begin
            k = m_cnt - 1;
            e_a = m_a[4*k +: 4];
            e_b = m_b[4*k +: 4];
            part = {1'b0, m_a & low_mask(k)} + {1'b0, eff_b(m_op, m_b) & low_mask(k)}
                 + {{W{1'b0}}, m_cin};
            e_ci = part[4*k];
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(m_cnt == N + 1));
        chk("result", 32'(result), 32'(m_res));
        chk("c_out", 32'(c_out), 32'(m_cout));
        chk("zero", 32'(zero), 32'(m_zero));
        chk("au_a", 32'(au_a), 32'(e_a));
        chk("au_b", 32'(au_b), 32'(e_b));
        chk("au_s", 32'(au_s), 32'(m_op));
        chk("au_c_in", 32'(au_c_in), 32'(e_ci));
    end

    // Run one operation; check latency, busy length and final outputs.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic ci, input logic [W-1:0] er,
                         input logic ec, input logic ez, output logic [3:0] cseq);
        int  edges, busy_cnt;
        bit  got;
        cseq = 4'h0;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; c_in = ci;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (busy) begin
                if (busy_cnt < 4) cseq[busy_cnt] = au_c_in;
                busy_cnt++;
            end
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
        end else begin
            chk({nm, "_latency"}, 32'(edges), 32'(N));
            chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
            chk({nm, "_result"}, 32'(result), 32'(er));
            chk({nm, "_c_out"}, 32'(c_out), 32'(ec));
            chk({nm, "_zero"}, 32'(zero), 32'(ez));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]   cs;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   full;
        int           dcnt;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add1", 2'b00, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, cs);
        do_op("sub1", 2'b01, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, cs);
        do_op("sub2", 2'b01, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, cs);
        do_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, cs);
        chk("add_wrap_carry_seq", 32'(cs), 32'h0000_000E);
        do_op("dec", 2'b11, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 1'b0, 1'b0, cs);
        do_op("pass", 2'b10, 16'hABCD, 16'h5555, 1'b1, 16'hABCE, 1'b0, 1'b0, cs);

        // start during RUN and DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1 || i == 4) begin
                start = 1'b1; op = 2'b01; a = 16'h9999; b = 16'h7777; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ignore_result", 32'(result), 32'h3333);
        chk("ignore_done_pulses", 32'(dcnt), 32'd1);

        // reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'h1357; b = 16'h2468; c_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_c_out", 32'(c_out), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'd0);
        do_op("post_rst_add", 2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, cs);

        // randomized operations against the full-width reference
        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = (t % 8 == 0) ? ~ra : 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, eff_b(ro, rb)} + {16'b0, rc};
            do_op("rand", ro, ra, rb, rc, full[W-1:0], full[W], full[W-1:0] == '0, cs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
# nibble_serial_alu_ctrl

Multi-cycle controller that performs WIDTH-bit arithmetic on the team's 4-bit arithmetic unit. It processes one nibble per clock, least-significant first, and chains the carry between cycles through a register. It sits on both sides of the 4-bit unit: it drives the unit's operands, select and carry-in, and captures the unit's sum and carry-out. Upstream logic sees a start/busy/done handshake with a full-width result.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4
- NIBBLES, WIDTH/4, derived; do not override

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- op  in  2  operation select, passed unchanged to au_s
- c_in  in  1  initial carry into nibble 0
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse; result/c_out/zero valid from this cycle
- result  out  WIDTH  final sum, held until next accepted start
- c_out  out  1  carry out of top nibble, held with result
- zero  out  1  result == 0, held with result
- au_a  out  4  current A nibble to arithmetic unit
- au_b  out  4  current B nibble to arithmetic unit
- au_s  out  2  select to arithmetic unit (= latched op)
- au_c_in  out  1  carry into arithmetic unit (= carry register)
- au_d  in  4  sum nibble from arithmetic unit (combinational)
- au_c_out  in  1  carry-out from arithmetic unit (combinational)

## Operation
- Op encoding, per nibble:
  - 00 ADD = A + B + cin
  - 01 SUB = A + ~B + cin (c_in=1 gives A−B)
  - 10 PASS = A + cin
  - 11 DEC = A + 4'hF + cin
- FSM with three states:
  - IDLE: start=1 latches a, b, op and c_in. It also loads carry←c_in, sets idx←0, clears result/c_out/zero, and goes to RUN. start=0 keeps the FSM in IDLE.
  - RUN: au_a=a_q[4·idx+:4], au_b=b_q[4·idx+:4], au_s=op_q, au_c_in=carry. Each edge: result[4·idx+:4]←au_d, carry←au_c_out, idx←idx+1. When idx=NIBBLES−1, go to DONE, with c_out←au_c_out and zero←(final result==0).
  - DONE: one cycle, then go to IDLE. start is ignored here.
- start in RUN or DONE is ignored; latched operands are never disturbed mid-operation.
- Outside RUN: au_a=0, au_b=0, au_s=op_q, au_c_in=0.
- busy = (state==RUN). done = (state==DONE). Both are registered-state decodes, not combinational from inputs.
- idx width is clog2(NIBBLES), minimum 1. Carry is never dropped between nibbles.
- Reset (asynchronous, at any time including mid-RUN):
  - state=IDLE; idx, carry and latched operands cleared
  - busy=0, done=0, result=0, c_out=0, zero=0
  - The aborted operation produces no done.

## Timing
- Edge E0: start accepted in IDLE.
- Edges E1..E_NIBBLES capture nibbles 0..NIBBLES−1.
- done is high in the cycle after edge E_NIBBLES. WIDTH=16 gives done 4 edges after acceptance; busy is high for exactly NIBBLES cycles.
- Next start is accepted at the edge ending the cycle after done (IDLE). Throughput is one operation per NIBBLES+2 cycles.
- au_d/au_c_out are sampled at the same edge that advances idx. The path is registers → arithmetic unit → registers, so it must close in one cycle.

## Structure
- Shared package alu_pkg holds:
  - state typedef (IDLE, RUN, DONE)
  - op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_PASS=2'b10, OP_DEC=2'b11
  - NIBBLE_W=4
- No sub-module inside this block. The datapath (nibble select and result insert) is inline. The 4-bit arithmetic unit is instantiated beside it in the enclosing level and wired via the au_* ports.

## Test plan
Bench uses WIDTH=16 with a behavioural 4-bit adder model on au_*.
- ADD, a=0x1234, b=0x0FCD, c_in=0 → result=0x2201, c_out=0, zero=0. done exactly 4 edges after acceptance; busy high 4 cycles.
- SUB, a=0x0005, b=0x0007, c_in=1 → result=0xFFFE, c_out=0. Then a=0x0007, b=0x0005 → 0x0002, c_out=1.
- ADD, a=0xFFFF, b=0x0001, c_in=0 → result=0x0000, c_out=1, zero=1. au_c_in reads 0,1,1,1 across nibbles 0..3.
- DEC, a=0x0000, c_in=0 → 0xFFFF, c_out=0. PASS, a=0xABCD, c_in=1 → 0xABCE.
- start pulsed during RUN and during DONE with different operands → ignored; first result unchanged and only one done pulse.
- rst_n low mid-RUN (after nibble 1) → all outputs 0 immediately, no done. New ADD 0x0001+0x0001 completes to 0x0002.
